// File: rtl/seq_sam_pkg.sv
// Shared types and width helpers for the sequential shift-and-add multiplier.
package seq_sam_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = $clog2(DEF_WIDTH) + 1;

   function automatic int cnt_width(int w);
      return $clog2(w) + 1;
   endfunction

   function automatic int prod_width(int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/sam_negate.sv
// Two's-complement negation, used for operand magnitudes and the sign fix.
module sam_negate #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);

   assign y = ~x + W'(1);

endmodule

// File: rtl/seq_sam_mult.sv
// Iterative shift-and-accumulate multiplier, one multiplier bit per clock,
// with signed/unsigned mode and valid/ready handshakes on both sides.
module seq_sam_mult
   import seq_sam_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result
);

   localparam int PW = prod_width(WIDTH);
   localparam int CW = cnt_width(WIDTH);

   state_t            state, state_n;
   logic [WIDTH-1:0]  mag_a, mag_b;
   logic [WIDTH-1:0]  neg_a, neg_b;
   logic [WIDTH-1:0]  b_sh;
   logic              neg;
   logic [PW-1:0]     acc, acc_n, addend, acc_neg;
   logic [CW-1:0]     count;
   logic              last;

   sam_negate #(.W(WIDTH)) u_neg_a (.x(a), .y(neg_a));
   sam_negate #(.W(WIDTH)) u_neg_b (.x(b), .y(neg_b));
   sam_negate #(.W(PW))    u_neg_p (.x(acc_n), .y(acc_neg));

   always_comb begin
      b_sh   = mag_b >> count;
      addend = '0;
      if (b_sh[0])
         addend = {{WIDTH{1'b0}}, mag_a} << count;
      acc_n  = acc + addend;
      last   = (count == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_n = BUSY;
         end
         BUSY: begin
            if (last)
               state_n = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Magnitudes are latched so the adder only ever sees unsigned terms.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mag_a  <= '0;
         mag_b  <= '0;
         neg    <= 1'b0;
         acc    <= '0;
         count  <= '0;
         result <= '0;
      end else if (state == IDLE && in_valid) begin
         mag_a <= (signed_mode && a[WIDTH-1]) ? neg_a : a;
         mag_b <= (signed_mode && b[WIDTH-1]) ? neg_b : b;
         neg   <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
         acc   <= '0;
         count <= '0;
      end else if (state == BUSY) begin
         acc   <= acc_n;
         count <= count + CW'(1);
         if (last)
            result <= neg ? acc_neg : acc_n;
      end
   end

endmodule
